brat_ckpt_ctrl: RTL and testbench

//  Allocation/recovery controller for the Branch RAT Copy Register (BRATCR) checkpoint array.

---
 rtl/brat_ckpt_ctrl.sv | 121 ++++++++++++
 tb/tb_brat_ckpt_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/brat_ckpt_ctrl.sv
// brat_ckpt_ctrl: allocates/frees BRAT checkpoint slots as a circular FIFO and sequences FRAT restore on mispredict.
module brat_ckpt_ctrl #(
  parameter int ISSUE_WIDTH    = 2,
  parameter int NUM_CKPT       = 4,
  parameter int ROB_SIZE_CLOG  = 5,
  parameter int RESTORE_CYCLES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ISSUE_WIDTH-1:0]                 br_val_id,
  input  logic [ISSUE_WIDTH*ROB_SIZE_CLOG-1:0]   br_robid_id,
  output logic                                   alloc_ok,
  output logic [NUM_CKPT-1:0]                    ckpt_wr_en,
  output logic [NUM_CKPT-1:0]                    ckpt_wr_src,
  input  logic                                   br_ret_val,
  input  logic [ROB_SIZE_CLOG-1:0]               br_ret_robid,
  input  logic                                   mispredict_val,
  input  logic [ROB_SIZE_CLOG-1:0]               mispredict_robid,
  output logic                                   restore_en,
  output logic [$clog2(NUM_CKPT)-1:0]            restore_slot,
  output logic                                   rename_stall,
  output logic                                   ckpt_full,
  output logic [$clog2(NUM_CKPT+1)-1:0]          ckpt_cnt,
  output logic                                   ckpt_err
);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int NW = $clog2(NUM_CKPT+1);
  localparam int RW = ROB_SIZE_CLOG;
  localparam int TW = $clog2(RESTORE_CYCLES+1);
  localparam logic [NW-1:0] FULL = NW'(NUM_CKPT);
  localparam logic [TW-1:0] LAST = TW'(RESTORE_CYCLES-1);

  typedef enum logic {S_IDLE, S_RESTORE} state_t;

  state_t              r_state, w_state_nxt;
  logic [TW-1:0]       r_rcnt, w_rcnt_nxt;
  logic [CW-1:0]       r_head, r_tail, r_slot, w_m, w_rank;
  logic [NUM_CKPT-1:0] r_valid, w_kill, w_wr_en, w_wr_src, w_ret_mask;
  logic [RW-1:0]       r_robid [NUM_CKPT];
  logic [RW-1:0]       w_wr_id [NUM_CKPT];
  logic [NW-1:0]       w_req, w_cnt;
  logic                r_err, w_idle, w_ok, w_ret, w_hit, w_mp, w_err;

  // Live count is the popcount of valid bits; the CAM keeps the lowest matching entry.
  always_comb begin
    w_req = '0;
    w_cnt = '0;
    w_hit = 1'b0;
    w_m   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) w_req = w_req + NW'(br_val_id[i]);
    for (int e = NUM_CKPT-1; e >= 0; e--) begin
      w_cnt = w_cnt + NW'(r_valid[e]);
      if (r_valid[e] && r_robid[e] == mispredict_robid) begin
        w_hit = 1'b1;
        w_m   = CW'(e);
      end
    end
    w_idle     = r_state == S_IDLE;
    w_ok       = rst_n & w_idle & ~mispredict_val & (w_req <= FULL - w_cnt);
    w_ret      = br_ret_val & r_valid[r_head] & (r_robid[r_head] == br_ret_robid);
    w_mp       = mispredict_val & w_idle & w_hit;
    w_err      = (br_ret_val & ~w_ret) | (mispredict_val & ~(w_idle & w_hit));
    w_ret_mask = NUM_CKPT'(w_ret) << r_head;
    for (int e = 0; e < NUM_CKPT; e++)
      w_kill[e] = w_mp & r_valid[e] & ((CW'(e) - r_head) >= (w_m - r_head));
  end

  // Branches are packed into consecutive entries starting at tail, oldest slot first.
  always_comb begin
    w_rank   = '0;
    w_wr_en  = '0;
    w_wr_src = '0;
    for (int e = 0; e < NUM_CKPT; e++) w_wr_id[e] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (w_ok && br_val_id[i]) begin
        w_wr_en[r_tail + w_rank]  = 1'b1;
        w_wr_src[r_tail + w_rank] = 1'(i);
        w_wr_id[r_tail + w_rank]  = br_robid_id[i*RW +: RW];
        w_rank = w_rank + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_idle ? (w_mp ? S_RESTORE : S_IDLE) : (r_rcnt == LAST ? S_IDLE : S_RESTORE);
    w_rcnt_nxt  = (w_idle || r_rcnt == LAST) ? '0 : r_rcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_slot  <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      for (int e = 0; e < NUM_CKPT; e++) r_robid[e] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_err   <= w_err;
      // A head retired while also being the mispredict target is already killed; head stays with tail.
      r_head  <= (w_ret && !(w_mp && w_m == r_head)) ? r_head + 1'b1 : r_head;
      r_tail  <= w_mp ? w_m : (w_ok ? r_tail + CW'(w_req) : r_tail);
      if (w_mp) r_slot <= w_m;
      r_valid <= (r_valid & ~w_kill & ~w_ret_mask) | w_wr_en;
      for (int e = 0; e < NUM_CKPT; e++) if (w_wr_en[e]) r_robid[e] <= w_wr_id[e];
    end
  end

  assign alloc_ok     = w_ok;
  assign ckpt_wr_en   = w_wr_en;
  assign ckpt_wr_src  = w_wr_src;
  assign restore_en   = (r_state == S_RESTORE) & (r_rcnt == '0);
  assign restore_slot = r_slot;
  assign rename_stall = rst_n & (((w_req != '0) & ~w_ok) | ~w_idle);
  assign ckpt_full    = w_cnt == FULL;
  assign ckpt_cnt     = w_cnt;
  assign ckpt_err     = r_err;
endmodule

// File: tb/tb_brat_ckpt_ctrl.sv
// tb_brat_ckpt_ctrl: directed vector table, async-reset-in-restore sequence and randomized run against a queue model.
module tb_brat_ckpt_ctrl;
  localparam int IW = 2, NC = 4, RW = 5, RC = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IW-1:0] br_val_id;
  logic [IW*RW-1:0] br_robid_id;
  logic alloc_ok, br_ret_val, mispredict_val, restore_en, rename_stall, ckpt_full, ckpt_err;
  logic [NC-1:0] ckpt_wr_en, ckpt_wr_src;
  logic [RW-1:0] br_ret_robid, mispredict_robid;
  logic [1:0] restore_slot;
  logic [2:0] ckpt_cnt;

  always #5 clk = ~clk;

  brat_ckpt_ctrl #(.ISSUE_WIDTH(IW), .NUM_CKPT(NC), .ROB_SIZE_CLOG(RW), .RESTORE_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .br_val_id(br_val_id), .br_robid_id(br_robid_id),
    .alloc_ok(alloc_ok), .ckpt_wr_en(ckpt_wr_en), .ckpt_wr_src(ckpt_wr_src),
    .br_ret_val(br_ret_val), .br_ret_robid(br_ret_robid),
    .mispredict_val(mispredict_val), .mispredict_robid(mispredict_robid),
    .restore_en(restore_en), .restore_slot(restore_slot), .rename_stall(rename_stall),
    .ckpt_full(ckpt_full), .ckpt_cnt(ckpt_cnt), .ckpt_err(ckpt_err));

  typedef struct {
    logic [1:0] bv; logic [4:0] r0, r1; logic rv; logic [4:0] rid; logic mv; logic [4:0] mid;
    logic ok; logic [3:0] wen, wsrc; logic ren; logic [1:0] slot; logic stall, full; logic [2:0] cnt; logic err;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  logic [RW-1:0] q[$];
  int m_head, m_rleft, m_slot;
  logic m_err;
  logic [RW-1:0] nrob;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] bv, input logic [4:0] r0, input logic [4:0] r1, input logic rv,
                       input logic [4:0] rid, input logic mv, input logic [4:0] mid);
    br_val_id = bv; br_robid_id = {r1, r0};
    br_ret_val = rv; br_ret_robid = rid;
    mispredict_val = mv; mispredict_robid = mid;
  endtask

  task automatic check_all(input string tag, input logic ok, input logic [3:0] wen, input logic [3:0] wsrc,
                           input logic ren, input logic [1:0] slot, input logic stall, input logic full,
                           input logic [2:0] cnt, input logic err);
    chk({tag, ".alloc_ok"}, 32'(alloc_ok), 32'(ok));
    chk({tag, ".wr_en"}, 32'(ckpt_wr_en), 32'(wen));
    chk({tag, ".wr_src"}, 32'(ckpt_wr_src), 32'(wsrc));
    chk({tag, ".restore_en"}, 32'(restore_en), 32'(ren));
    chk({tag, ".restore_slot"}, 32'(restore_slot), 32'(slot));
    chk({tag, ".stall"}, 32'(rename_stall), 32'(stall));
    chk({tag, ".full"}, 32'(ckpt_full), 32'(full));
    chk({tag, ".cnt"}, 32'(ckpt_cnt), 32'(cnt));
    chk({tag, ".err"}, 32'(ckpt_err), 32'(err));
  endtask

  function automatic vec_t v(input logic [1:0] bv, input logic [4:0] r0, input logic [4:0] r1, input logic rv,
                             input logic [4:0] rid, input logic mv, input logic [4:0] mid, input logic ok,
                             input logic [3:0] wen, input logic [3:0] wsrc, input logic ren, input logic [1:0] slot,
                             input logic stall, input logic full, input logic [2:0] cnt, input logic err);
    vec_t t;
    t.bv = bv; t.r0 = r0; t.r1 = r1; t.rv = rv; t.rid = rid; t.mv = mv; t.mid = mid;
    t.ok = ok; t.wen = wen; t.wsrc = wsrc; t.ren = ren; t.slot = slot;
    t.stall = stall; t.full = full; t.cnt = cnt; t.err = err;
    return t;
  endfunction

  initial begin
    vec_t tv[20];
    logic [1:0] bv;
    logic rv, mv, e_ok, e_ren, e_stall, e_full, e_err, ret, hit;
    logic [4:0] rid, mid;
    logic [3:0] e_wen, e_wsrc;
    int sz, req, tl, k, p;
    // bv r0 r1 rv rid mv mid | ok wen wsrc ren slot stall full cnt err
    tv[0]  = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tv[1]  = v(2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0011, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tv[2]  = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0);
    tv[3]  = v(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0);
    tv[4]  = v(2'b11, 5'd6, 5'd7, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 3'd3, 1'b0);
    tv[5]  = v(2'b11, 5'd6, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b1001, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0);
    tv[6]  = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 3'd4, 1'b0);
    tv[7]  = v(2'b01, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0);
    tv[8]  = v(2'b01, 5'd8, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0);
    tv[9]  = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0, 3'd1, 1'b0);
    tv[10] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 3'd1, 1'b0);
    tv[11] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd1, 1'b1);
    tv[12] = v(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd1, 1'b0);
    tv[13] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd1, 1'b1);
    tv[14] = v(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd1, 1'b0);
    tv[15] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    tv[16] = v(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    tv[17] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1);
    tv[18] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1);
    tv[19] = v(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0);

    drive(2'b11, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 5'd3);
    #3 check_all("reset", 1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tv[i].bv, tv[i].r0, tv[i].r1, tv[i].rv, tv[i].rid, tv[i].mv, tv[i].mid);
      #2 check_all($sformatf("vec%0d", i), tv[i].ok, tv[i].wen, tv[i].wsrc, tv[i].ren, tv[i].slot,
                   tv[i].stall, tv[i].full, tv[i].cnt, tv[i].err);
    end

    // Reset asserted in the middle of a restore: outputs must clear without a clock edge.
    @(negedge clk) drive(2'b11, 5'd10, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
    #2 chk("rst_seq.alloc", 32'(ckpt_wr_en), 32'(4'b1100));
    @(negedge clk) drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11);
    @(negedge clk) drive(2'b11, 5'd12, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
    #2 chk("rst_seq.restore_en", 32'(restore_en), 32'(1'b1));
    chk("rst_seq.slot", 32'(restore_slot), 32'(2'd3));
    #1 rst_n = 1'b0;
    #1 check_all("rst_mid", 1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    #2 check_all("post_rst", 1'b1, 4'b0011, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk) drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #2 chk("post_rst.cnt", 32'(ckpt_cnt), 32'(3'd2));

    @(negedge clk) rst_n = 1'b0;
    q.delete(); m_head = 0; m_rleft = 0; m_slot = 0; m_err = 1'b0; nrob = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      sz  = q.size();
      bv  = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv  = $urandom_range(0, 9) < 4;
      rid = (sz > 0 && $urandom_range(0, 3) != 0) ? q[0] : 5'($urandom_range(0, 31));
      mv  = $urandom_range(0, 11) == 0;
      mid = (sz > 0 && $urandom_range(0, 2) != 0) ? q[$urandom_range(0, sz-1)] : 5'($urandom_range(0, 31));
      drive(bv, nrob, nrob + 5'(bv[0]), rv, rid, mv, mid);
      req = int'(bv[0]) + int'(bv[1]);
      tl  = (m_head + sz) % NC;
      e_ok = (m_rleft == 0) && !mv && (req <= NC - sz);
      e_wen = '0; e_wsrc = '0; k = 0;
      for (int i = 0; i < IW; i++)
        if (e_ok && bv[i]) begin
          e_wen[(tl + k) % NC] = 1'b1;
          e_wsrc[(tl + k) % NC] = 1'(i);
          k++;
        end
      e_ren   = m_rleft == RC;
      e_stall = (req != 0 && !e_ok) || m_rleft > 0;
      e_full  = sz == NC;
      e_err   = m_err;
      #2 check_all($sformatf("rnd%0d", it), e_ok, e_wen, e_wsrc, e_ren, 2'(m_slot), e_stall, e_full, 3'(sz), e_err);
      ret = rv && sz > 0 && q[0] == rid;
      p = -1;
      if (m_rleft == 0)
        for (int j = 0; j < sz; j++) if (p < 0 && q[j] == mid) p = j;
      hit = mv && p >= 0;
      m_err = (rv && !ret) || (mv && !hit);
      if (hit) begin
        m_slot = (m_head + p) % NC;
        while (q.size() > p) void'(q.pop_back());
        m_rleft = RC;
      end else if (m_rleft > 0) m_rleft--;
      if (ret && !(hit && p == 0)) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % NC;
      end
      if (e_ok) begin
        for (int i = 0; i < IW; i++) if (bv[i]) q.push_back(nrob + 5'(i == 1 && bv[0]));
        nrob = nrob + 5'(req);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
